bcd_to_bin: RTL and testbench

Iterative converter that reads a packed vector of BCD digits, as produced by the chained BCD add/subtract digit cells, and returns the equivalent unsigned binary value. It implements reverse double-dabble: one right shift plus per-digit correction per clock, behind a start/done handshake. It sits between the BCD accumulator chain and any binary consumer, such as a comparator or a binary-to-display path.

---
 rtl/bcd_pkg.sv | 33 +++
 rtl/bcd_dabble_digit.sv | 28 ++
 rtl/bcd_to_bin.sv | 130 +++++++++++++
 tb/tb_bcd_to_bin.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and configuration helper for the
// BCD-to-binary converter and its per-digit correction cell.
package bcd_pkg;

   localparam int DIGIT_W       = 4;
   localparam int BCD_MAX       = 9;
   localparam int DABBLE_THRESH = 8;
   localparam int DABBLE_ADJ    = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Smallest binary width able to hold 10^digits - 1.
   function automatic int min_bin_w(input int digits);
      longint unsigned span;
      int bits;
      span = 64'd1;
      for (int i = 0; i < digits; i++) begin
         span = span * 64'd10;
      end
      bits = 0;
      for (int b = 0; b < 64; b++) begin
         if ((64'd1 << b) < span) begin
            bits = b + 1;
         end
      end
      return bits;
   endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One BCD digit of reverse double-dabble: after a right shift a digit that
// reads 8 or more had a 1 shifted in from the digit above (worth 8 here but
// only 5 in decimal), so 3 is removed. Also flags non-decimal digit codes.
module bcd_dabble_digit
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] d,
   output logic [DIGIT_W-1:0] q,
   output logic               invalid
);

   localparam logic [DIGIT_W-1:0] THRESH = DIGIT_W'(DABBLE_THRESH);
   localparam logic [DIGIT_W-1:0] ADJ    = DIGIT_W'(DABBLE_ADJ);
   localparam logic [DIGIT_W-1:0] MAXD   = DIGIT_W'(BCD_MAX);

   // Per-digit correction (4-bit, no carry out) and range check.
   always_comb begin
      q       = d;
      invalid = 1'b0;
      if (d >= THRESH) begin
         q = d - ADJ;
      end
      if (d > MAXD) begin
         invalid = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_to_bin.sv
// Iterative packed-BCD to unsigned binary converter (reverse double-dabble).
// One right shift plus per-digit correction per clock behind a start/done
// handshake; invalid digit codes short-circuit straight to DONE with err set.
module bcd_to_bin
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [4*DIGITS-1:0]     bcd_in,
   output logic                    ready,
   output logic                    busy,
   output logic                    done,
   output logic [BIN_W-1:0]        bin_out,
   output logic                    err
);

   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   generate
      if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_cfg
         $error("bcd_to_bin: BIN_W too small for the number of BCD digits");
      end
   endgenerate

   state_t                   state;
   state_t                   state_nxt;
   logic [CNT_W-1:0]         cnt;
   logic [BCD_W-1:0]         bcd_q;
   logic [BIN_W-1:0]         bin_q;
   logic [BCD_W+BIN_W-1:0]   shifted;
   logic [BCD_W-1:0]         dig_in;
   logic [BCD_W-1:0]         dig_out;
   logic [DIGITS-1:0]        dig_bad;
   logic                     any_bad;
   logic                     last_shift;
   logic                     accept;

   // The BCD LSB falls into the binary MSB on every shift.
   assign shifted = {bcd_q, bin_q} >> 1;

   // The digit cells check the incoming word while idle and correct the
   // shifted BCD field while converting, so one set of cells serves both.
   assign dig_in = (state == ST_IDLE) ? bcd_in : shifted[BCD_W+BIN_W-1 -: BCD_W];

   generate
      for (genvar g = 0; g < DIGITS; g++) begin : g_digit
         bcd_dabble_digit u_digit (
            .d       (dig_in[g*DIGIT_W +: DIGIT_W]),
            .q       (dig_out[g*DIGIT_W +: DIGIT_W]),
            .invalid (dig_bad[g])
         );
      end
   endgenerate

   assign any_bad    = |dig_bad;
   assign last_shift = (cnt == CNT_W'(1));
   assign accept     = (state == ST_IDLE) && start;

   assign ready = (state == ST_IDLE);
   assign busy  = (state == ST_SHIFT);
   assign done  = (state == ST_DONE);

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: start is only looked at while idle.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = any_bad ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (last_shift) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Iteration counter and result registers; results move only on DONE entry.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt     <= '0;
         bin_out <= '0;
         err     <= 1'b0;
      end else begin
         if (accept) begin
            cnt <= CNT_W'(BIN_W);
            if (any_bad) begin
               bin_out <= '0;
               err     <= 1'b1;
            end
         end else if (state == ST_SHIFT) begin
            cnt <= cnt - CNT_W'(1);
            if (last_shift) begin
               bin_out <= shifted[BIN_W-1:0];
               err     <= 1'b0;
            end
         end
      end
   end

   // Working shift register: loaded on a valid accept, shifted while busy.
   always_ff @(posedge clk) begin
      if (accept && !any_bad) begin
         bcd_q <= bcd_in;
         bin_q <= '0;
      end else if (state == ST_SHIFT) begin
         bcd_q <= dig_out;
         bin_q <= shifted[BIN_W-1:0];
      end
   end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Bench for bcd_to_bin: directed cases plus random BCD words, checked against
// a decimal-arithmetic reference model.
module tb_bcd_to_bin;

   localparam int DIGITS = 4;
   localparam int BIN_W  = 14;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic [4*DIGITS-1:0] bcd_in;
   logic                ready;
   logic                busy;
   logic                done;
   logic [BIN_W-1:0]    bin_out;
   logic                err;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .bcd_in  (bcd_in),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .bin_out (bin_out),
      .err     (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: decimal weighting of the digits; any digit above 9 is an error.
   function automatic void model(input logic [15:0] v, output logic [31:0] val, output logic e);
      int p;
      p   = 1;
      val = 0;
      e   = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         int d;
         d = int'(v[4*i +: 4]);
         if (d > 9) e = 1'b1;
         val = val + 32'(d * p);
         p = p * 10;
      end
      if (e) val = 0;
   endfunction

   // Called at a falling edge with the DUT idle; returns at a falling edge
   // with the DUT idle again.
   task automatic convert(input logic [15:0] v, input string tag);
      logic [31:0] ev;
      logic        ee;
      int          cyc;
      int          bcnt;
      model(v, ev, ee);
      check({tag, "/ready"}, 32'(ready), 32'd1);
      start  = 1'b1;
      bcd_in = v;
      @(negedge clk);
      start  = 1'b0;
      bcd_in = 16'($urandom);
      cyc  = 1;
      bcnt = 0;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy === 1'b1) bcnt++;
         @(negedge clk);
         cyc++;
      end
      check({tag, "/latency"}, 32'(cyc), ee ? 32'd1 : 32'(BIN_W + 1));
      check({tag, "/busy_cycles"}, 32'(bcnt), ee ? 32'd0 : 32'(BIN_W));
      check({tag, "/bin_out"}, 32'(bin_out), ev);
      check({tag, "/err"}, 32'(err), 32'(ee));
      @(negedge clk);
      check({tag, "/done_pulse"}, 32'(done), 32'd0);
      check({tag, "/ready_after"}, 32'(ready), 32'd1);
      check({tag, "/bin_hold"}, 32'(bin_out), ev);
   endtask

   initial begin
      int          dcnt;
      logic [31:0] cap;
      logic [15:0] v;

      reset  = 1'b0;
      start  = 1'b0;
      bcd_in = '0;
      repeat (3) @(negedge clk);
      check("rst/busy", 32'(busy), 32'd0);
      check("rst/done", 32'(done), 32'd0);
      check("rst/bin_out", 32'(bin_out), 32'd0);
      check("rst/err", 32'(err), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("rst/ready", 32'(ready), 32'd1);

      convert(16'h0000, "zero");
      convert(16'h1234, "d1234");
      convert(16'h9999, "d9999");
      convert(16'h0001, "d0001_b2b");
      convert(16'h12A4, "bad12A4");
      convert(16'h0042, "d0042");
      convert(16'hF000, "badF000");
      convert(16'h8080, "d8080");

      // A start pulse during SHIFT must be ignored.
      start  = 1'b1;
      bcd_in = 16'h0007;
      @(negedge clk);
      start  = 1'b0;
      @(negedge clk);
      start  = 1'b1;
      bcd_in = 16'h5555;
      @(negedge clk);
      start  = 1'b0;
      dcnt = 0;
      cap  = 32'hFFFF_FFFF;
      repeat (30) begin
         if (done === 1'b1) begin
            dcnt++;
            cap = 32'(bin_out);
         end
         @(negedge clk);
      end
      check("ignore/done_count", 32'(dcnt), 32'd1);
      check("ignore/bin_out", cap, 32'd7);
      check("ignore/ready", 32'(ready), 32'd1);

      // Reset in the 5th SHIFT cycle aborts the conversion.
      start  = 1'b1;
      bcd_in = 16'h8888;
      @(negedge clk);
      start  = 1'b0;
      repeat (4) @(negedge clk);
      check("abort/busy_before", 32'(busy), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      check("abort/ready", 32'(ready), 32'd1);
      check("abort/busy", 32'(busy), 32'd0);
      check("abort/bin_out", 32'(bin_out), 32'd0);
      check("abort/err", 32'(err), 32'd0);
      reset = 1'b1;
      dcnt = 0;
      repeat (25) begin
         if (done === 1'b1) dcnt++;
         @(negedge clk);
      end
      check("abort/no_done", 32'(dcnt), 32'd0);

      // Random words, mostly valid digits with occasional invalid codes.
      repeat (40) begin
         for (int i = 0; i < DIGITS; i++) begin
            if ($urandom_range(0, 7) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
            else                           v[4*i +: 4] = 4'($urandom_range(0, 9));
         end
         convert(v, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
